return_addr_stack: RTL and testbench

//  Parametrised return-address stack (RAS) for link-type control flow (beqal, jal, jalr).

---
 rtl/return_addr_stack.sv | 163 ++++++++++++++++
 tb/tb_return_addr_stack.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/return_addr_stack.sv
// -----------------------------------------------------------------------------
// return_addr_stack
//   Return-address stack for link-type control flow. Fetch pushes the link
//   address (PC+4) when a linking branch is taken; a retiring return pops it,
//   which gives a predicted return target one cycle early. Storage is a
//   circular buffer addressed by a write pointer. When the stack is full, the
//   overflow policy either overwrites the oldest entry or discards the new push.
//
// Parameters
//   WIDTH          address width in bits
//   DEPTH          number of entries (power of two, >= 2)
//   OVERFLOW_MODE  0 = WRAP (overwrite oldest entry), 1 = DROP (discard push)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   push         push push_addr this cycle
//   push_addr    link address to store
//   pop          pop top entry this cycle
//   flush        synchronous stack clear; push/pop ignored that cycle
//   clear_flags  clear sticky overflow/underflow (a same-cycle set wins)
//   top_addr     current top entry, 0 when empty (from registered state)
//   top_valid    stack not empty (from registered state)
//   count        number of valid entries, 0..DEPTH (registered)
//   overflow     sticky: a push arrived while full
//   underflow    sticky: a pop arrived while empty
// -----------------------------------------------------------------------------
module return_addr_stack #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned OVERFLOW_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_addr,
    input  logic                         pop,
    input  logic                         flush,
    input  logic                         clear_flags,
    output logic [WIDTH-1:0]             top_addr,
    output logic                         top_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry storage; intentionally not reset, top_addr masks it while empty.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wp;
    logic [AW-1:0] wp_nxt;
    logic [AW-1:0] wp_m1;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          overflow_nxt;
    logic          underflow_nxt;

    logic          we;
    logic [AW-1:0] waddr;
    logic          ovf_set;
    logic          unf_set;
    logic          empty;
    logic          full;

    // Pointer math is modulo DEPTH; the AW-bit width provides the wrap.
    assign wp_m1 = wp - AW'(1);
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // Next-state decode: flush has priority over the push/pop combination.
    always_comb begin
        wp_nxt    = wp;
        count_nxt = count_q;
        we        = 1'b0;
        waddr     = wp;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        if (flush) begin
            wp_nxt    = '0;
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!full) begin
                        we        = 1'b1;
                        wp_nxt    = wp + AW'(1);
                        count_nxt = count_q + CW'(1);
                    end else begin
                        ovf_set = 1'b1;
                        // WRAP overwrites the oldest slot, which is the one at wp.
                        if (OVERFLOW_MODE == 0) begin
                            we     = 1'b1;
                            wp_nxt = wp + AW'(1);
                        end
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        wp_nxt    = wp_m1;
                        count_nxt = count_q - CW'(1);
                    end else begin
                        unf_set = 1'b1;
                    end
                end
                2'b11: begin
                    if (!empty) begin
                        // Return immediately followed by a call: replace top in place.
                        we    = 1'b1;
                        waddr = wp_m1;
                    end else begin
                        we        = 1'b1;
                        wp_nxt    = wp + AW'(1);
                        count_nxt = CW'(1);
                        unf_set   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle beats clear_flags.
    always_comb begin
        overflow_nxt  = ovf_set | (overflow  & ~clear_flags);
        underflow_nxt = unf_set | (underflow & ~clear_flags);
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp        <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wp        <= wp_nxt;
            count_q   <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    // Entry write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= push_addr;
        end
    end

    // Read side is combinational from registered state: no extra latency.
    always_comb begin
        count     = count_q;
        top_valid = !empty;
        top_addr  = empty ? '0 : mem[wp_m1];
    end

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [31:0] push_addr;
    logic        pop;
    logic        flush;
    logic        clear_flags;

    always #5 clk = ~clk;

    // Three instances share the stimulus: default config, DEPTH=4 WRAP, DEPTH=4 DROP.
    logic [31:0] top8, top4w, top4d;
    logic        vld8, vld4w, vld4d;
    logic [3:0]  cnt8;
    logic [2:0]  cnt4w, cnt4d;
    logic        ovf8, ovf4w, ovf4d;
    logic        unf8, unf4w, unf4d;

    return_addr_stack #(.WIDTH(32), .DEPTH(8), .OVERFLOW_MODE(0)) u_d8 (
        .clk(clk), .rst_n(rst_n), .push(push), .push_addr(push_addr), .pop(pop),
        .flush(flush), .clear_flags(clear_flags), .top_addr(top8), .top_valid(vld8),
        .count(cnt8), .overflow(ovf8), .underflow(unf8));

    return_addr_stack #(.WIDTH(32), .DEPTH(4), .OVERFLOW_MODE(0)) u_d4w (
        .clk(clk), .rst_n(rst_n), .push(push), .push_addr(push_addr), .pop(pop),
        .flush(flush), .clear_flags(clear_flags), .top_addr(top4w), .top_valid(vld4w),
        .count(cnt4w), .overflow(ovf4w), .underflow(unf4w));

    return_addr_stack #(.WIDTH(32), .DEPTH(4), .OVERFLOW_MODE(1)) u_d4d (
        .clk(clk), .rst_n(rst_n), .push(push), .push_addr(push_addr), .pop(pop),
        .flush(flush), .clear_flags(clear_flags), .top_addr(top4d), .top_valid(vld4d),
        .count(cnt4d), .overflow(ovf4d), .underflow(unf4d));

    logic [31:0] top_o [3];
    logic [31:0] cnt_o [3];
    logic        vld_o [3];
    logic        ovf_o [3];
    logic        unf_o [3];

    always_comb begin
        top_o[0] = top8;  top_o[1] = top4w;  top_o[2] = top4d;
        cnt_o[0] = 32'(cnt8); cnt_o[1] = 32'(cnt4w); cnt_o[2] = 32'(cnt4d);
        vld_o[0] = vld8;  vld_o[1] = vld4w;  vld_o[2] = vld4d;
        ovf_o[0] = ovf8;  ovf_o[1] = ovf4w;  ovf_o[2] = ovf4d;
        unf_o[0] = unf8;  unf_o[1] = unf4w;  unf_o[2] = unf4d;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: array with oldest entry at index 0, shifted on WRAP overflow.
    logic [31:0] mst [3][8];
    int          mcnt [3];
    bit          movf [3];
    bit          munf [3];
    int          mdepth [3] = '{8, 4, 4};
    int          mmode  [3] = '{0, 0, 1};

    typedef struct {
        logic [31:0] top;
        int          cnt;
        bit          vld;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t sbq [$];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            movf[k] = 1'b0;
            munf[k] = 1'b0;
        end
        sbq.delete();
    endtask

    task automatic model_step(input int k, input bit p, input bit po, input bit f,
                              input bit c, input logic [31:0] a);
        int d;
        bit os;
        bit us;
        d  = mdepth[k];
        os = 1'b0;
        us = 1'b0;
        if (f) begin
            mcnt[k] = 0;
        end else if (p && !po) begin
            if (mcnt[k] < d) begin
                mst[k][mcnt[k]] = a;
                mcnt[k]++;
            end else begin
                os = 1'b1;
                if (mmode[k] == 0) begin
                    for (int i = 0; i < d - 1; i++) mst[k][i] = mst[k][i+1];
                    mst[k][d-1] = a;
                end
            end
        end else if (!p && po) begin
            if (mcnt[k] > 0) mcnt[k]--;
            else us = 1'b1;
        end else if (p && po) begin
            if (mcnt[k] > 0) begin
                mst[k][mcnt[k]-1] = a;
            end else begin
                mst[k][0] = a;
                mcnt[k]   = 1;
                us        = 1'b1;
            end
        end
        movf[k] = os | (movf[k] & !c);
        munf[k] = us | (munf[k] & !c);
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.cnt = mcnt[k];
        e.vld = (mcnt[k] != 0);
        e.top = (mcnt[k] != 0) ? mst[k][mcnt[k]-1] : 32'h0;
        e.ovf = movf[k];
        e.unf = munf[k];
        return e;
    endfunction

    // One clock of stimulus: expectations go into the scoreboard before the edge,
    // then are popped and compared against all three instances after it.
    task automatic step(input bit p, input bit po, input bit f, input bit c,
                        input logic [31:0] a);
        exp_t e;
        push = p; pop = po; flush = f; clear_flags = c; push_addr = a;
        for (int k = 0; k < 3; k++) begin
            model_step(k, p, po, f, c, a);
            sbq.push_back(model_out(k));
        end
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clear_flags = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (sbq.size() == 0) begin
                chk($sformatf("sb_empty[%0d]", k), 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("sb_top[%0d]", k), top_o[k], e.top);
                chk($sformatf("sb_cnt[%0d]", k), cnt_o[k], 32'(e.cnt));
                chk($sformatf("sb_vld[%0d]", k), 32'(vld_o[k]), 32'(e.vld));
                chk($sformatf("sb_ovf[%0d]", k), 32'(ovf_o[k]), 32'(e.ovf));
                chk($sformatf("sb_unf[%0d]", k), 32'(unf_o[k]), 32'(e.unf));
            end
        end
    endtask

    // Reset asserted mid-cycle; outputs must drop before any clock edge.
    task automatic pulse_reset(input string nm);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_top[%0d]", nm, k), top_o[k], 32'h0);
            chk($sformatf("%s_cnt[%0d]", nm, k), cnt_o[k], 32'h0);
            chk($sformatf("%s_vld[%0d]", nm, k), 32'(vld_o[k]), 32'h0);
            chk($sformatf("%s_ovf[%0d]", nm, k), 32'(ovf_o[k]), 32'h0);
            chk($sformatf("%s_unf[%0d]", nm, k), 32'(unf_o[k]), 32'h0);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          p;
        bit          po;
        logic [31:0] a;
        logic [31:0] w_top;
        int          w_cnt;
        bit          w_ovf;
        bit          w_unf;
        logic [31:0] d_top;
        int          d_cnt;
        bit          d_ovf;
        bit          d_unf;
    } vec_t;

    vec_t vt [10];

    initial begin
        rst_n = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clear_flags = 1'b0;
        push_addr = 32'h0;

        // DEPTH=4 overflow vectors: WRAP vs DROP under identical stimulus.
        vt[0] = '{1'b1, 1'b0, 32'd4,  32'd4,  1, 1'b0, 1'b0, 32'd4,  1, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 32'd8,  32'd8,  2, 1'b0, 1'b0, 32'd8,  2, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 32'd12, 32'd12, 3, 1'b0, 1'b0, 32'd12, 3, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 32'd16, 32'd16, 4, 1'b0, 1'b0, 32'd16, 4, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b0, 32'd20, 32'd20, 4, 1'b1, 1'b0, 32'd16, 4, 1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b1, 32'd0,  32'd16, 3, 1'b1, 1'b0, 32'd12, 3, 1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 32'd0,  32'd12, 2, 1'b1, 1'b0, 32'd8,  2, 1'b1, 1'b0};
        vt[7] = '{1'b0, 1'b1, 32'd0,  32'd8,  1, 1'b1, 1'b0, 32'd4,  1, 1'b1, 1'b0};
        vt[8] = '{1'b0, 1'b1, 32'd0,  32'd0,  0, 1'b1, 1'b0, 32'd0,  0, 1'b1, 1'b0};
        vt[9] = '{1'b0, 1'b1, 32'd0,  32'd0,  0, 1'b1, 1'b1, 32'd0,  0, 1'b1, 1'b1};

        @(posedge clk);
        #1;
        pulse_reset("reset");

        for (int i = 0; i < 10; i++) begin
            step(vt[i].p, vt[i].po, 1'b0, 1'b0, vt[i].a);
            chk($sformatf("wrap_top[%0d]", i), top4w, vt[i].w_top);
            chk($sformatf("wrap_cnt[%0d]", i), 32'(cnt4w), 32'(vt[i].w_cnt));
            chk($sformatf("wrap_ovf[%0d]", i), 32'(ovf4w), 32'(vt[i].w_ovf));
            chk($sformatf("wrap_unf[%0d]", i), 32'(unf4w), 32'(vt[i].w_unf));
            chk($sformatf("drop_top[%0d]", i), top4d, vt[i].d_top);
            chk($sformatf("drop_cnt[%0d]", i), 32'(cnt4d), 32'(vt[i].d_cnt));
            chk($sformatf("drop_ovf[%0d]", i), 32'(ovf4d), 32'(vt[i].d_ovf));
            chk($sformatf("drop_unf[%0d]", i), 32'(unf4d), 32'(vt[i].d_unf));
        end

        // Basic push/pop.
        pulse_reset("reset2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd12);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd20);
        chk("basic_top", top8, 32'd20);
        chk("basic_cnt", 32'(cnt8), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("basic_pop_top", top8, 32'd12);
        chk("basic_pop_cnt", 32'(cnt8), 32'd2);

        // Simultaneous push & pop: replace top, then the empty-stack case.
        pulse_reset("reset3");
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd12);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd40);
        chk("pp_top", top8, 32'd40);
        chk("pp_cnt", 32'(cnt8), 32'd2);
        chk("pp_unf", 32'(unf8), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("pp_pop_top", top8, 32'd4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'd8);
        chk("pp_empty_cnt", 32'(cnt8), 32'd1);
        chk("pp_empty_top", top8, 32'd8);
        chk("pp_empty_unf", 32'(unf8), 32'd1);

        // Flush holds flags; clear_flags loses to a same-cycle underflow.
        pulse_reset("reset4");
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd8);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd12);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'd99);
        chk("flush_cnt", 32'(cnt8), 32'd0);
        chk("flush_top", top8, 32'd0);
        chk("flush_unf", 32'(unf8), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        chk("clr_vs_set_unf", 32'(unf8), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        chk("clr_unf", 32'(unf8), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd16);
        pulse_reset("reset_mid");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            int r;
            bit p, po, f, c;
            r  = int'($urandom_range(0, 99));
            p  = (r < 55);
            po = (int'($urandom_range(0, 99)) < 45);
            f  = (int'($urandom_range(0, 99)) < 3);
            c  = (int'($urandom_range(0, 99)) < 8);
            step(p, po, f, c, {$urandom} & 32'hffff_fffc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
